// File: rtl/booth_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_div_pkg                                                          |
// | Shared constants for the sequential signed divider.                    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package booth_div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  // Ceiling log2, used to size the iteration counter as clog2(WIDTH+1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_div_absconv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_div_absconv                                                      |
// | Sign extraction and optional two's-complement negation, WIDTH in,      |
// | WIDTH+1 out. Used for operand magnitudes and for the final sign fix.   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module booth_div_absconv
  import booth_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic             sign,
  output logic [WIDTH:0]   magnitude
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] value_ext;

  assign sign      = value[WIDTH-1];
  assign value_ext = {value[WIDTH-1], value};
  assign magnitude = negate ? (~value_ext + ONE) : value_ext;

endmodule
`default_nettype wire

// File: rtl/booth_signed_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_signed_divider                                                   |
// | Radix-2 restoring signed divider, one quotient bit per clock, with a   |
// | start/busy/done handshake. Optional macro BOOTH_DIV_APPROX_EN skips    |
// | the low APPROX_BITS quotient bits and zeroes the remainder.            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module booth_signed_divider
  import booth_div_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

`ifdef BOOTH_DIV_APPROX_EN
  localparam int SKIP = APPROX_BITS;
`else
  // Exact build: APPROX_BITS has no effect.
  localparam int SKIP = APPROX_BITS * 0;
`endif

  localparam int               ITER    = WIDTH - SKIP;
  localparam int               CNT_W   = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] dvd_q,       dvd_d;
  logic [WIDTH:0]   dsr_q,       dsr_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic             dvd_neg_q,   dvd_neg_d;
  logic             dsr_neg_q,   dsr_neg_d;
  logic             ovf_q,       ovf_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q,      done_d;
  logic             dbz_q,       dbz_d;
  logic             overflow_q,  overflow_d;

  logic [WIDTH:0]   dvd_abs, dsr_abs, quo_fix, rem_fix;
  logic             dvd_sign, dsr_sign, quo_sign, rem_sign;
  logic [WIDTH-1:0] quo_mag, rem_src;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic             unused_bits;

  booth_div_absconv #(.WIDTH(WIDTH)) u_abs_dvd (
    .value(dividend), .negate(dividend[WIDTH-1]), .sign(dvd_sign), .magnitude(dvd_abs)
  );
  booth_div_absconv #(.WIDTH(WIDTH)) u_abs_dsr (
    .value(divisor), .negate(divisor[WIDTH-1]), .sign(dsr_sign), .magnitude(dsr_abs)
  );
  booth_div_absconv #(.WIDTH(WIDTH)) u_fix_quo (
    .value(quo_mag), .negate(dvd_neg_q ^ dsr_neg_q), .sign(quo_sign), .magnitude(quo_fix)
  );
  booth_div_absconv #(.WIDTH(WIDTH)) u_fix_rem (
    .value(rem_src), .negate(dvd_neg_q), .sign(rem_sign), .magnitude(rem_fix)
  );

  assign quo_mag = quo_q << SKIP;
  // The divide-by-zero path returns the dividend by re-signing its captured magnitude.
  assign rem_src = (state_q == S_ZERO) ? dvd_q : rem_q;
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {1'b0, dsr_q};
  // A kept difference is always below the divisor magnitude, so both top bits are clear.
  assign ge      = (diff[WIDTH+1:WIDTH] == 2'b00);

  assign unused_bits = &{1'b0, dvd_abs[WIDTH], quo_fix[WIDTH], rem_fix[WIDTH], quo_sign, rem_sign};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvd_neg_d   = dvd_neg_q;
    dsr_neg_d   = dsr_neg_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d     = dvd_abs[WIDTH-1:0];
          dsr_d     = dsr_abs;
          dvd_neg_d = dvd_sign;
          dsr_neg_d = dsr_sign;
          ovf_d     = (dividend == MIN_VAL) && (divisor == {WIDTH{1'b1}});
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          state_d   = (divisor == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[WIDTH-2:0], ge};
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = quo_fix[WIDTH-1:0];
`ifdef BOOTH_DIV_APPROX_EN
        remainder_d = '0;
`else
        remainder_d = rem_fix[WIDTH-1:0];
`endif
        dbz_d       = 1'b0;
        overflow_d  = ovf_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      S_ZERO: begin
        quotient_d  = {WIDTH{1'b1}};
        remainder_d = rem_fix[WIDTH-1:0];
        dbz_d       = 1'b1;
        overflow_d  = 1'b0;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_neg_q   <= 1'b0;
      dsr_neg_q   <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_neg_q   <= dvd_neg_d;
      dsr_neg_q   <= dsr_neg_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_signed_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_booth_signed_divider                                                |
// | Directed self-checking bench for booth_signed_divider (WIDTH=8).       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_booth_signed_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  booth_signed_divider #(.WIDTH(8), .APPROX_BITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int a, input int b);
    dividend = a[7:0];
    divisor  = b[7:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Edge count e0 includes the accepting edge.
  task automatic wait_done(input int e0, output int edges);
    edges = e0;
    while (done !== 1'b1 && edges < 64) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input int q, input int r, input int dbz, input int ovf);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_quotient"}, $signed(quotient), q);
    check({tag, "_remainder"}, $signed(remainder), r);
    check({tag, "_div_by_zero"}, div_by_zero, dbz);
    check({tag, "_overflow"}, overflow, ovf);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int exp_lat,
                        input int q, input int r, input int dbz, input int ovf);
    int lat;
    accept(a, b);
    check({tag, "_busy"}, busy, 1);
    wait_done(1, lat);
    check_result(tag, lat, exp_lat, q, r, dbz, ovf);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_div_by_zero"}, div_by_zero, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_cleared("reset");

`ifdef BOOTH_DIV_APPROX_EN
    run_op("apx_100_7", 100, 7, 8, 12, 0, 0, 0);
    run_op("apx_m100_7", -100, 7, 8, -12, 0, 0, 0);
    run_op("apx_45_0", 45, 0, 2, -1, 45, 1, 0);
`else
    run_op("m34_100", -34, 100, 10, 0, -34, 0, 0);
    run_op("100_m13", 100, -13, 10, -7, 9, 0, 0);
    run_op("m45_15", -45, 15, 10, -3, 0, 0, 0);
    run_op("m128_m1", -128, -1, 10, -128, 0, 0, 1);
    run_op("45_0", 45, 0, 2, -1, 45, 1, 0);

    tick();
    check("hold_done", done, 0);
    check("hold_div_by_zero", div_by_zero, 1);
    check("hold_quotient", $signed(quotient), -1);

    // Start pulsed mid-operation must not disturb -25/15.
    accept(-25, 15);
    repeat (3) tick();
    dividend = 8'd7;
    divisor  = 8'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(5, lat);
    check_result("m25_15", lat, 10, -1, -10, 0, 0);

    // Start issued in the done cycle is accepted on the following edge.
    accept(7, 2);
    wait_done(1, lat);
    check_result("b2b_7_2", lat, 10, 3, 1, 0, 0);
    count_done(20, pulses);
    check("no_extra_done", pulses, 0);

    accept(100, -13);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("abort");
    count_done(15, pulses);
    check("abort_no_done", pulses, 0);
    run_op("127_m128", 127, -128, 10, 0, 127, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_signed_divider.md
Name: booth_signed_divider

Overview:
Sequential signed integer divider. It is the inverse-direction companion to the team's signed Booth multiplier in the FPGA accelerator datapath.
Computes quotient and remainder of two's-complement WIDTH-bit operands using a radix-2 restoring algorithm on magnitudes, one quotient bit per clock.
Used for normalisation and rescaling after multiply-accumulate stages; uses a start/busy/done handshake toward the accelerator controller.

Parameters:
WIDTH, 8, operand/quotient/remainder bit width (signed, two's complement); legal range 4..32.
APPROX_BITS, 2, number of low quotient bits skipped when BOOTH_DIV_APPROX_EN is defined; must be < WIDTH.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
dividend  input  WIDTH  signed dividend; captured on the accepting edge.
divisor  input  WIDTH  signed divisor; captured on the accepting edge.
busy  output  1  high from the cycle after acceptance until done.
done  output  1  one-cycle pulse; results valid in this cycle.
quotient  output  WIDTH  signed quotient, truncated toward zero.
remainder  output  WIDTH  signed remainder; sign follows the dividend.
div_by_zero  output  1  error flag for the last operation.
overflow  output  1  flag set when the operation was -2^(WIDTH-1) / -1.

Behaviour:
- Reset (sync, active-high): state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - Reset mid-operation aborts with no done pulse; the next accepted start runs normally.
- States:
  - IDLE: on start=1, capture operand signs and absolute values (WIDTH+1-bit internal to hold |-2^(W-1)|), clear the counter, then:
    - go to ZERO if divisor==0;
    - otherwise go to CALC.
  - CALC: per cycle, shift the partial remainder left by one and bring in the next dividend magnitude bit. Trial-subtract the divisor magnitude:
    - if non-negative, keep the result and set quotient bit=1;
    - otherwise restore and set quotient bit=0.
    - After WIDTH iterations, go to FIX.
  - FIX: apply signs.
    - Negate the quotient if the operand signs differ.
    - Negate the remainder if the dividend is negative.
    - Register the outputs, assert done for one cycle, then go to IDLE.
  - ZERO: quotient=all-ones (-1), remainder=dividend, div_by_zero=1, done=1, then go to IDLE.
- Latency: done is high in the cycle following the (WIDTH+2)th rising edge counted from the accepting edge (10 for WIDTH=8). The divide-by-zero path has a latency of 2 edges.
- Back-to-back: start may be asserted in the same cycle as done. It is accepted on the next edge, because the state is IDLE by then.
- start while busy=1: ignored; the captured operands are unaffected.
- Overflow case -2^(W-1) / -1: the quotient wraps to -2^(W-1), remainder=0, overflow=1.
- Flags update only at done and hold until the next done or reset.
- quotient and remainder hold their last values between operations.
- Exact identity when no flag is set: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.

Optional Feature:
BOOTH_DIV_APPROX_EN:
- Defined: CALC runs WIDTH-APPROX_BITS iterations. The low APPROX_BITS quotient-magnitude bits are forced to 0 before sign fix. remainder is forced to 0. Latency drops by APPROX_BITS.
- Undefined: exact behaviour as above; APPROX_BITS is ignored.

Decomposition:
- Package booth_div_pkg: state enumeration (IDLE, CALC, FIX, ZERO), default WIDTH constant, and the counter-width function clog2(WIDTH+1).
- Sub-module booth_div_absconv: combinational sign extraction plus WIDTH-to-(WIDTH+1) absolute value. It is instantiated for both operands and reused in reverse for the FIX negation.

Test Plan:
- Reset then dividend=-34, divisor=100, start -> done after 10 edges; quotient=0, remainder=-34, flags 0.
- dividend=100, divisor=-13 -> quotient=-7, remainder=9. Then dividend=-45, divisor=15 -> quotient=-3, remainder=0.
- dividend=-128, divisor=-1 -> quotient=-128, remainder=0, overflow=1. Then dividend=45, divisor=0 -> done after 2 edges; quotient=-1, remainder=45, div_by_zero=1, overflow=0.
- Pulse start with new operands (7/2) while busy during -25/15 -> result is quotient=-1, remainder=-10 only, with a single done pulse. A start issued in the done cycle -> 7/2 gives quotient=3, remainder=1.
- Assert rst 4 cycles into CALC -> no done; all outputs 0. Next 127/-128 -> quotient=0, remainder=127.
- With BOOTH_DIV_APPROX_EN, APPROX_BITS=2: 100/7 -> done after 8 edges; quotient=12, remainder=0.
